// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: opcode map, the idle NOP word
// and the FSM state encoding.
package seq_pkg;

  localparam logic [3:0]  OP_LDI   = 4'h0;
  localparam logic [3:0]  OP_HALT  = 4'h5;
  localparam logic [3:0]  OP_NOP   = 4'h6;
  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program buffer: DEPTH x 16 words, async reset to NOP_WORD, synchronous write,
// combinational read so a word written at an edge is visible to the next fetch.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PCW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [PCW-1:0] waddr,
  input  logic [15:0]    wdata,
  input  logic [PCW-1:0] raddr,
  output logic [15:0]    rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: issues buffered instruction words one per clock until HALT
// or end of buffer. Optional repeat feature enabled by defining SEQ_LOOP_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PCW   = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PCW-1:0]  prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            start,
  input  logic            hold,
`ifdef SEQ_LOOP_EN
  input  logic [3:0]      loop_cnt,
`endif
  output logic [15:0]     instruction,
  output logic            issue_valid,
  output logic [PCW-1:0]  pc,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] issued_count
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] fetch_p0;
  logic        is_halt_p0, at_end_p0, pass_end_p0, again;

  seq_prog_mem #(.DEPTH(DEPTH), .PCW(PCW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (prog_we && (state == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (fetch_p0)
  );

  assign is_halt_p0  = (fetch_p0[15:12] == OP_HALT);
  assign at_end_p0   = (pc == PCW'(DEPTH - 1));
  assign pass_end_p0 = (state == RUN) && !hold && (is_halt_p0 || at_end_p0);

`ifdef SEQ_LOOP_EN
  logic [3:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      remaining <= loop_cnt;
    end else if (pass_end_p0 && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign again = (remaining != '0);
`else
  assign again = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pass_end_p0 && !again) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Issue stage: the fetched word is registered onto the datapath interface.
  // HALT and hold cycles issue a NOP bubble so nothing is skipped or repeated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      instruction  <= NOP_WORD;
      issue_valid  <= 1'b0;
      issued_count <= '0;
    end else begin
      instruction <= NOP_WORD;
      issue_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pc           <= '0;
          issued_count <= '0;
        end
        RUN: if (!hold) begin
          if (is_halt_p0) begin
            if (again) pc <= '0;
          end else begin
            instruction  <= fetch_p0;
            issue_valid  <= 1'b1;
            issued_count <= sat_inc(issued_count);
            pc           <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; the repeat scenario is
// exercised only when SEQ_LOOP_EN is defined.
module tb_instr_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic        hold;
`ifdef SEQ_LOOP_EN
  logic [3:0]  loop_cnt;
`endif
  logic [15:0] instruction;
  logic        issue_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  issued_count;

  int compared   = 0;
  int mismatched = 0;

  instr_sequencer #(.DEPTH(16), .PCW(4), .CNTW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .hold         (hold),
`ifdef SEQ_LOOP_EN
    .loop_cnt     (loop_cnt),
`endif
    .instruction  (instruction),
    .issue_valid  (issue_valid),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic issue_chk(input string tag, input logic [15:0] w, input logic [3:0] p);
    check({tag, "_instr"}, 32'(instruction), 32'(w));
    check({tag, "_vld"}, 32'(issue_valid), 32'(1));
    check({tag, "_pc"}, 32'(pc), 32'(p));
  endtask

  task automatic load_prog2;
    load(4'd0, 16'h0053);
    load(4'd1, 16'h0074);
    load(4'd2, 16'h8345);
    load(4'd3, 16'h5000);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; hold = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_cnt = 4'd0;
`endif
    tick(); tick();
    check("rst_instr", 32'(instruction), 32'h6000);
    check("rst_vld", 32'(issue_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_cnt", 32'(issued_count), 32'(0));
    rst = 1'b0;
    tick();

    // Basic program ending in HALT
    load_prog2();
    start = 1'b1; tick(); start = 1'b0;
    check("t2_busy", 32'(busy), 32'(1));
    check("t2_bubble", 32'(issue_valid), 32'(0));
    tick(); issue_chk("t2_w0", 16'h0053, 4'd1);
    check("t2_cnt1", 32'(issued_count), 32'(1));
    tick(); issue_chk("t2_w1", 16'h0074, 4'd2);
    tick(); issue_chk("t2_w2", 16'h8345, 4'd3);
    tick();
    check("t2_halt_instr", 32'(instruction), 32'h6000);
    check("t2_halt_vld", 32'(issue_valid), 32'(0));
    check("t2_done", 32'(done), 32'(1));
    check("t2_busy_done", 32'(busy), 32'(0));
    tick();
    check("t2_done_end", 32'(done), 32'(0));
    check("t2_cnt", 32'(issued_count), 32'(3));

    // Hold for two cycles after the first issue
    start = 1'b1; tick(); start = 1'b0;
    tick(); issue_chk("t3_w0", 16'h0053, 4'd1);
    hold = 1'b1;
    tick();
    check("t3_h1_instr", 32'(instruction), 32'h6000);
    check("t3_h1_vld", 32'(issue_valid), 32'(0));
    check("t3_h1_pc", 32'(pc), 32'(1));
    tick();
    check("t3_h2_vld", 32'(issue_valid), 32'(0));
    check("t3_h2_pc", 32'(pc), 32'(1));
    check("t3_h2_cnt", 32'(issued_count), 32'(1));
    hold = 1'b0;
    tick(); issue_chk("t3_w1", 16'h0074, 4'd2);
    tick(); issue_chk("t3_w2", 16'h8345, 4'd3);
    tick();
    check("t3_done", 32'(done), 32'(1));
    check("t3_cnt", 32'(issued_count), 32'(3));
    tick();

    // Write and start while running are ignored
    start = 1'b1; tick(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h1234; start = 1'b1;
    tick(); issue_chk("t6_w0", 16'h0053, 4'd1);
    prog_we = 1'b0; start = 1'b0;
    tick(); issue_chk("t6_w1", 16'h0074, 4'd2);
    tick(); tick();
    check("t6_done", 32'(done), 32'(1));
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); issue_chk("t6_rerun_w0", 16'h0053, 4'd1);
    tick(); tick(); tick(); tick();
    check("t6_idle", 32'(busy), 32'(0));

    // Full buffer without HALT: wrap to 0 and finish
    for (int i = 0; i < 16; i++) load(4'(i), 16'h8000);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t4_instr", 32'(instruction), 32'h8000);
      check("t4_vld", 32'(issue_valid), 32'(1));
    end
    check("t4_pc_wrap", 32'(pc), 32'(0));
    check("t4_done", 32'(done), 32'(1));
    check("t4_cnt", 32'(issued_count), 32'(16));
    tick();
    check("t4_after_instr", 32'(instruction), 32'h6000);
    check("t4_after_done", 32'(done), 32'(0));

    // Async reset mid-run, then run the NOP-filled buffer
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t5_pc2", 32'(pc), 32'(2));
    rst = 1'b1;
    #2;
    check("t5_rst_instr", 32'(instruction), 32'h6000);
    check("t5_rst_vld", 32'(issue_valid), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_pc", 32'(pc), 32'(0));
    check("t5_rst_cnt", 32'(issued_count), 32'(0));
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t5_instr", 32'(instruction), 32'h6000);
      check("t5_vld", 32'(issue_valid), 32'(1));
    end
    check("t5_done", 32'(done), 32'(1));
    check("t5_cnt", 32'(issued_count), 32'(16));
    tick();

`ifdef SEQ_LOOP_EN
    begin
      int issues = 0;
      int dones  = 0;
      load_prog2();
      loop_cnt = 4'd2;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (issue_valid) issues++;
        if (done) dones++;
      end
      check("loop_issues", 32'(issues), 32'(9));
      check("loop_dones", 32'(dones), 32'(1));
      check("loop_cnt", 32'(issued_count), 32'(9));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
